dram_read_arbiter: RTL and testbench
====================================

Name: dram_read_arbiter

Overview:
- Shares the single DRAM read port between two requesters: the ifmap row FIFO fill path and the weight loader.
- Round-robin arbitration with bursts: one grant is held for a whole burst.
- Issues read addresses and tracks in-flight beats through a fixed-latency return pipeline, then routes each returning word to the requester that issued it.
- Sits between the DRAM model and the ifmap FIFO / weight register file, replacing a free-running read address counter.

Parameters:
- ADDR_W, 10, DRAM word-address width.
- DATA_W, 32, DRAM read data width.
- RD_LAT, 2, cycles from dram_rd_en to dram_rd_data valid; legal range 1..4.
- IF_BURST, 4, words per ifmap grant (one row segment).
- IF_LIMIT, 512, ifmap address wraps from IF_LIMIT-1 to 0.
- W_BASE, 512, first weight word address.
- W_WORDS, 36, total weight words per load.
- W_BURST, 9, maximum words per weight grant.

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset: asynchronous, active-low.
- if_req, input, 1, level: ifmap path wants data.
- if_space, input, 1, ifmap FIFO can accept at least RD_LAT+1 more words.
- w_start, input, 1, pulse: start a weight load.
- w_space, input, 1, weight sink can accept at least RD_LAT+1 more words.
- dram_rd_en, output, 1, read strobe.
- dram_rd_addr, output, ADDR_W, read address.
- dram_rd_data, input, DATA_W, read data, valid RD_LAT cycles after the strobe.
- if_wr_en, output, 1, write strobe to the ifmap FIFO.
- if_wr_data, output, DATA_W, data to the ifmap FIFO.
- w_wr_en, output, 1, write strobe to the weight sink.
- w_wr_data, output, DATA_W, data to the weight sink.
- w_busy, output, 1, weight load pending or in flight.
- w_done, output, 1, one-cycle pulse when a weight load completes.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, last_owner=W, if_addr=0, w_addr=W_BASE, w_remaining=0.
  - Return pipeline cleared; in-flight beats are dropped.
  - All outputs 0, except dram_rd_addr, which is 0 (muxed from if_addr).
- w_start when w_busy=0: w_remaining<=W_WORDS, w_addr<=W_BASE, w_busy<=1 next cycle. w_start while w_busy=1 is ignored.
- Pending conditions: if_pend=if_req; w_pend=(w_remaining>0).
- State machine:
  - IDLE:
    - Both pending: grant the one that is not last_owner.
    - Only one pending: grant it.
    - On grant: load burst_cnt=IF_BURST (ifmap) or min(W_BURST, w_remaining) (weight); go to IF_BURST or W_BURST.
  - IF_BURST / W_BURST:
    - A beat issues when the owner's space=1: dram_rd_en=1 combinationally; the address counter increments.
    - burst_cnt decrements on each issued beat; w_remaining also decrements for weight beats.
    - If space=0, the burst pauses with the grant held and dram_rd_en=0.
    - After the beat that makes burst_cnt 0: set last_owner=owner, go to IDLE.
  - There is always one IDLE cycle between bursts. No preemption.
- if_req deasserting mid-burst does not end the burst; the burst completes.
- Address rules:
  - dram_rd_addr = if_addr in IDLE/IF_BURST, w_addr in W_BURST.
  - if_addr wraps IF_LIMIT-1 -> 0.
  - w_addr is linear from W_BASE.
- Return pipeline:
  - RD_LAT-stage shift register of {valid, owner}, fed with {dram_rd_en, owner}.
  - When the tail is valid: assert the owner's wr_en in the same cycle as dram_rd_data, with wr_data=dram_rd_data.
  - The non-owner's wr_en stays 0.
  - wr_data outputs pass dram_rd_data through unconditionally.
- Weight completion:
  - w_done pulses one cycle after the last weight word's w_wr_en.
  - w_busy falls in the same cycle w_done rises.
- Weight load simultaneous with w_start: none is possible, because w_start is ignored while busy.
- Throughput: at most one issue per cycle; issue and return can overlap every cycle.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- Defined: adds outputs if_stall_cnt[15:0] and w_stall_cnt[15:0].
  - Each counts cycles in which that requester is pending but issues no beat.
  - Counters saturate at 16'hFFFF and clear on reset only.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- if_req=1, if_space=1, no weights -> bursts of 4 reads, addresses 0-3, idle cycle, 4-7...; if_wr_en exactly RD_LAT cycles after each dram_rd_en.
- w_start pulse, if_req=0 -> 36 reads from 512..547 in 4 bursts of 9; w_done pulse one cycle after the 36th w_wr_en; w_busy then 0.
- if_req=1 and w_start together -> after reset (last_owner=W) grant ifmap 0-3, then weight 512-520, then ifmap 4-7, alternating.
- if_space drops for 3 cycles mid ifmap burst -> dram_rd_en=0 for those 3 cycles, grant held, addresses continue without skip.
- if_addr at 510 with continuous if_req -> addresses 510, 511, 0, 1.
- rst low with 2 beats in flight -> no if_wr_en or w_wr_en afterwards; state IDLE; if_addr=0; w_busy=0.

Source files
------------

// File: rtl/dram_read_arbiter.sv
// Round-robin burst arbiter sharing the DRAM read port between ifmap and weights.
// Define ARB_PERF_CNT_EN to add per-requester stall counters.
module dram_read_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int RD_LAT   = 2,
  parameter int IF_BURST = 4,
  parameter int IF_LIMIT = 512,
  parameter int W_BASE   = 512,
  parameter int W_WORDS  = 36,
  parameter int W_BURST  = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic              if_space,
  input  logic              w_start,
  input  logic              w_space,
  output logic              dram_rd_en,
  output logic [ADDR_W-1:0] dram_rd_addr,
  input  logic [DATA_W-1:0] dram_rd_data,
  output logic              if_wr_en,
  output logic [DATA_W-1:0] if_wr_data,
  output logic              w_wr_en,
  output logic [DATA_W-1:0] w_wr_data,
  output logic              w_busy,
  output logic              w_done
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [15:0]       if_stall_cnt,
  output logic [15:0]       w_stall_cnt
`endif
);

  localparam int BMAX = (IF_BURST > W_BURST) ? IF_BURST : W_BURST;
  localparam int BC_W = $clog2(BMAX + 1);
  localparam int RM_W = $clog2(W_WORDS + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_IF, ST_W} state_t;

  state_t            r_state;
  state_t            w_state_nx;
  logic              r_last_w;
  logic              w_last_nx;
  logic [BC_W-1:0]   r_bcnt;
  logic [BC_W-1:0]   w_bcnt_nx;
  logic [ADDR_W-1:0] r_if_addr;
  logic [ADDR_W-1:0] r_w_addr;
  logic [RM_W-1:0]   r_w_rem;
  logic [RM_W-1:0]   r_w_ret;
  logic              r_w_busy;
  logic              r_w_done;
  logic [RD_LAT-1:0] r_pv;
  logic [RD_LAT-1:0] r_po;

  logic w_if_pend;
  logic w_w_pend;
  logic w_issue;
  logic w_own_w;
  logic w_start_ok;
  logic w_last_ret;

  always_comb begin
    w_if_pend  = if_req;
    w_w_pend   = (r_w_rem != '0);
    w_own_w    = (r_state == ST_W);
    w_issue    = 1'b0;
    w_state_nx = r_state;
    w_bcnt_nx  = r_bcnt;
    w_last_nx  = r_last_w;
    unique case (r_state)
      ST_IDLE: begin
        if (w_if_pend && (r_last_w || !w_w_pend)) begin
          w_state_nx = ST_IF;
          w_bcnt_nx  = BC_W'(IF_BURST);
        end else if (w_w_pend) begin
          w_state_nx = ST_W;
          w_bcnt_nx  = (r_w_rem > RM_W'(W_BURST)) ?
                       BC_W'(W_BURST) : BC_W'(r_w_rem);
        end
      end
      ST_IF:   w_issue = if_space;
      ST_W:    w_issue = w_space;
      default: w_state_nx = ST_IDLE;
    endcase
    if (w_issue) begin
      w_bcnt_nx = r_bcnt - BC_W'(1);
      if (r_bcnt == BC_W'(1)) begin
        w_state_nx = ST_IDLE;
        w_last_nx  = w_own_w;
      end
    end
  end

  assign w_start_ok   = w_start && !r_w_busy;
  assign dram_rd_en   = w_issue;
  assign dram_rd_addr = w_own_w ? r_w_addr : r_if_addr;
  assign if_wr_en     = r_pv[RD_LAT-1] && !r_po[RD_LAT-1];
  assign w_wr_en      = r_pv[RD_LAT-1] && r_po[RD_LAT-1];
  assign if_wr_data   = dram_rd_data;
  assign w_wr_data    = dram_rd_data;
  assign w_busy       = r_w_busy;
  assign w_done       = r_w_done;
  assign w_last_ret   = w_wr_en && (r_w_ret == RM_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_last_w  <= 1'b1;
      r_bcnt    <= '0;
      r_if_addr <= '0;
      r_w_addr  <= ADDR_W'(W_BASE);
      r_w_rem   <= '0;
      r_w_ret   <= '0;
      r_w_busy  <= 1'b0;
      r_w_done  <= 1'b0;
      r_pv      <= '0;
      r_po      <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_bcnt   <= w_bcnt_nx;
      r_last_w <= w_last_nx;
      r_pv[0]  <= w_issue;
      r_po[0]  <= w_own_w;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_po[i] <= r_po[i-1];
      end
      if (w_issue && !w_own_w)
        r_if_addr <= (r_if_addr == ADDR_W'(IF_LIMIT - 1)) ?
                     '0 : r_if_addr + ADDR_W'(1);
      if (w_start_ok) begin
        r_w_addr <= ADDR_W'(W_BASE);
        r_w_rem  <= RM_W'(W_WORDS);
      end else if (w_issue && w_own_w) begin
        r_w_addr <= r_w_addr + ADDR_W'(1);
        r_w_rem  <= r_w_rem - RM_W'(1);
      end
      // returned-word count keeps busy high until the last word lands
      if (w_start_ok)
        r_w_ret <= RM_W'(W_WORDS);
      else if (w_wr_en)
        r_w_ret <= r_w_ret - RM_W'(1);
      r_w_done <= w_last_ret;
      if (w_start_ok)
        r_w_busy <= 1'b1;
      else if (w_last_ret)
        r_w_busy <= 1'b0;
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [15:0] r_if_stall;
  logic [15:0] r_w_stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_if_stall <= '0;
      r_w_stall  <= '0;
    end else begin
      if (w_if_pend && !(w_issue && !w_own_w) && (r_if_stall != 16'hFFFF))
        r_if_stall <= r_if_stall + 16'd1;
      if (w_w_pend && !(w_issue && w_own_w) && (r_w_stall != 16'hFFFF))
        r_w_stall <= r_w_stall + 16'd1;
    end
  end

  assign if_stall_cnt = r_if_stall;
  assign w_stall_cnt  = r_w_stall;
`endif

endmodule

// File: tb/tb_dram_read_arbiter.sv
// Scoreboard bench for dram_read_arbiter: directed vectors, queued expectations,
// negedge monitor comparing issued addresses and routed return words.
module tb_dram_read_arbiter;

  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic        if_space = 1'b1;
  logic        w_start = 1'b0;
  logic        w_space = 1'b1;
  logic        dram_rd_en;
  logic [9:0]  dram_rd_addr;
  logic [31:0] dram_rd_data;
  logic        if_wr_en;
  logic [31:0] if_wr_data;
  logic        w_wr_en;
  logic [31:0] w_wr_data;
  logic        w_busy;
  logic        w_done;
`ifdef ARB_PERF_CNT_EN
  logic [15:0] if_stall_cnt;
  logic [15:0] w_stall_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int n_rd = 0;
  int n_done = 0;
  int w_wr_cnt = 0;
  int last_w_cyc = -10;
  int exp_rd[$];
  logic [32:0] exp_wr[$];
  int pend_t[$];

  logic [RD_LAT-1:0] dv = '0;
  logic [9:0] da[RD_LAT];

  always #5 clk = ~clk;

  dram_read_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .if_req       (if_req),
    .if_space     (if_space),
    .w_start      (w_start),
    .w_space      (w_space),
    .dram_rd_en   (dram_rd_en),
    .dram_rd_addr (dram_rd_addr),
    .dram_rd_data (dram_rd_data),
    .if_wr_en     (if_wr_en),
    .if_wr_data   (if_wr_data),
    .w_wr_en      (w_wr_en),
    .w_wr_data    (w_wr_data),
    .w_busy       (w_busy),
    .w_done       (w_done)
`ifdef ARB_PERF_CNT_EN
    ,
    .if_stall_cnt (if_stall_cnt),
    .w_stall_cnt  (w_stall_cnt)
`endif
  );

  function automatic logic [31:0] data_of(int a);
    return 32'hA500_0000 | 32'(a);
  endfunction

  always @(posedge clk) begin
    dv[0] <= dram_rd_en;
    da[0] <= dram_rd_addr;
    for (int i = 1; i < RD_LAT; i++) begin
      dv[i] <= dv[i-1];
      da[i] <= da[i-1];
    end
  end

  assign dram_rd_data = dv[RD_LAT-1] ?
                        data_of(int'(da[RD_LAT-1])) : 32'hDEAD_BEEF;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      pend_t.delete();
      w_wr_cnt = 0;
    end else begin
      if (dram_rd_en) begin
        n_rd++;
        pend_t.push_back(cyc);
        if (exp_rd.size() == 0)
          chk("rd_unexpected", 64'(dram_rd_addr), 64'hFFFF);
        else
          chk("rd_addr", 64'(dram_rd_addr), 64'(exp_rd.pop_front()));
      end
      if (if_wr_en && w_wr_en)
        chk("wr_both", 1, 0);
      if (if_wr_en || w_wr_en) begin
        if (exp_wr.size() == 0)
          chk("wr_unexpected", 1, 0);
        else
          chk("wr_word", {w_wr_en, w_wr_en ? w_wr_data : if_wr_data},
              64'(exp_wr.pop_front()));
        if (pend_t.size() == 0)
          chk("wr_latency", 64'hFFFF, RD_LAT);
        else
          chk("wr_latency", 64'(cyc - pend_t.pop_front()), RD_LAT);
      end
      if (w_wr_en) begin
        w_wr_cnt++;
        last_w_cyc = cyc;
      end
      if (w_done) begin
        n_done++;
        chk("w_done_count", 64'(w_wr_cnt), 36);
        chk("w_done_time", 64'(cyc - last_w_cyc), 1);
        chk("w_busy_fall", 64'(w_busy), 0);
        w_wr_cnt = 0;
      end
    end
  end

  task automatic push(int a, bit w);
    exp_rd.push_back(a);
    exp_wr.push_back({w, data_of(a)});
  endtask

  task automatic wait_rd(int target, int budget);
    int k = 0;
    while (n_rd < target && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    if (n_rd < target) chk("wait_rd_timeout", 64'(n_rd), 64'(target));
  endtask

  task automatic wait_done(int target, int budget);
    int k = 0;
    while (n_done < target && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    chk("w_done_seen", 64'(n_done), 64'(target));
  endtask

  task automatic drain(int budget);
    int k = 0;
    while ((exp_wr.size() != 0 || exp_rd.size() != 0) && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    chk("drain_rd", 64'(exp_rd.size()), 0);
    chk("drain_wr", 64'(exp_wr.size()), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n0;
    int t4;
    int d0;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rd_en", 64'(dram_rd_en), 0);
    chk("rst_rd_addr", 64'(dram_rd_addr), 0);
    chk("rst_w_busy", 64'(w_busy), 0);
    chk("rst_w_done", 64'(w_done), 0);
    chk("rst_if_wr", 64'(if_wr_en), 0);
    chk("rst_w_wr", 64'(w_wr_en), 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // ifmap-only streaming: 0-3, idle, 4-7
    n0 = n_rd;
    for (int a = 0; a < 8; a++) push(a, 1'b0);
    @(posedge clk); #1;
    if_req = 1'b1;
    wait_rd(n0 + 4, 50);
    t4 = cyc;
    wait_rd(n0 + 5, 10);
    chk("if_idle_gap", 64'(cyc - t4), 2);
    wait_rd(n0 + 8, 20);
    @(posedge clk); #1;
    if_req = 1'b0;
    drain(20);

    // weight load 512..547, second w_start while busy is ignored
    d0 = n_done;
    n0 = n_rd;
    for (int a = 512; a < 548; a++) push(a, 1'b1);
    @(posedge clk); #1;
    w_start = 1'b1;
    @(posedge clk); #1;
    w_start = 1'b0;
    @(negedge clk); #1;
    chk("w_busy_rise", 64'(w_busy), 1);
    wait_rd(n0 + 20, 100);
    @(posedge clk); #1;
    w_start = 1'b1;
    @(posedge clk); #1;
    w_start = 1'b0;
    wait_done(d0 + 1, 200);
    drain(20);
    repeat (4) @(negedge clk);
    #1;
    chk("w_busy_idle", 64'(w_busy), 0);
    chk("w_single_done", 64'(n_done), 64'(d0 + 1));

    // reset, then if_req and w_start together: alternate grants
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    d0 = n_done;
    n0 = n_rd;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 4; i++) push(4 * b + i, 1'b0);
      for (int i = 0; i < 9; i++) push(512 + 9 * b + i, 1'b1);
    end
    @(posedge clk); #1;
    if_req  = 1'b1;
    w_start = 1'b1;
    @(posedge clk); #1;
    w_start = 1'b0;
    wait_rd(n0 + 52, 200);
    @(posedge clk); #1;
    if_req = 1'b0;
    wait_done(d0 + 1, 50);
    drain(20);

    // if_space low for 3 cycles mid burst: 16..23 without skip
    n0 = n_rd;
    for (int a = 16; a < 24; a++) push(a, 1'b0);
    @(posedge clk); #1;
    if_req = 1'b1;
    wait_rd(n0 + 2, 50);
    @(posedge clk); #1;
    if_space = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      chk("stall_rd_en", 64'(dram_rd_en), 0);
      chk("stall_addr", 64'(dram_rd_addr), 18);
      @(posedge clk); #1;
    end
    if_space = 1'b1;
    wait_rd(n0 + 8, 50);
    @(posedge clk); #1;
    if_req = 1'b0;
    drain(20);

    // address wrap: 24..511 then 0..3
    n0 = n_rd;
    for (int a = 24; a < 512; a++) push(a, 1'b0);
    for (int a = 0; a < 4; a++) push(a, 1'b0);
    @(posedge clk); #1;
    if_req = 1'b1;
    wait_rd(n0 + 492, 800);
    @(posedge clk); #1;
    if_req = 1'b0;
    drain(20);

    // reset with two weight beats in flight
    d0 = n_done;
    n0 = n_rd;
    exp_rd.push_back(512);
    exp_rd.push_back(513);
    @(posedge clk); #1;
    w_start = 1'b1;
    @(posedge clk); #1;
    w_start = 1'b0;
    wait_rd(n0 + 2, 50);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    chk("rst2_rd_en", 64'(dram_rd_en), 0);
    chk("rst2_addr", 64'(dram_rd_addr), 0);
    chk("rst2_w_busy", 64'(w_busy), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (5) begin
      @(negedge clk); #1;
      chk("rst2_no_wwr", 64'(w_wr_en), 0);
      chk("rst2_no_ifwr", 64'(if_wr_en), 0);
    end
    chk("rst2_no_done", 64'(n_done), 64'(d0));
    chk("rst2_rd_left", 64'(exp_rd.size()), 0);

    // if_addr restarted at 0
    n0 = n_rd;
    for (int a = 0; a < 4; a++) push(a, 1'b0);
    @(posedge clk); #1;
    if_req = 1'b1;
    wait_rd(n0 + 4, 20);
    @(posedge clk); #1;
    if_req = 1'b0;
    drain(20);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
